project_select_ctrl: RTL and testbench



---
 rtl/project_select_ctrl.sv | 176 +++++++++++++++++
 tb/tb_project_select_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/project_select_ctrl.sv
// Wishbone-programmable project selector for the user_project_wrapper.
// Every project change goes through a break-before-make guard so no two projects ever drive the pads together.
`timescale 1ns/1ps

module project_select_ctrl #(
  parameter int          NPROJ     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [7:0]  GUARD_RST = 8'd16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic [NPROJ-1:0] active,
  output logic             busy,
  output logic             switch_irq
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_APPLY = 2'd2;

  // Word offsets within the 256-byte window.
  localparam logic [5:0] OFF_SEL    = 6'd0;
  localparam logic [5:0] OFF_GUARD  = 6'd1;
  localparam logic [5:0] OFF_STATUS = 6'd2;

  logic [1:0]       r_state;
  logic [7:0]       r_gcnt;
  logic             r_pending;
  logic [4:0]       r_req_idx;
  logic             r_req_en;
  logic [7:0]       r_guard;
  logic [4:0]       r_cur_idx;
  logic             r_cur_en;
  logic [15:0]      r_switch_cnt;
  logic [NPROJ-1:0] r_active;
  logic             r_busy;
  logic             r_irq;
  logic             r_ack;
  logic [31:0]      r_dat;

  logic             w_hit;
  logic             w_req;
  logic             w_wr;
  logic             w_sel_wr;
  logic             w_guard_wr;
  logic             w_req_en_eff;
  logic             w_same;
  logic [NPROJ-1:0] w_req_onehot;
  logic [31:0]      w_rdata;
  logic             w_unused;

  // ---------------------------------------------------------------------------
  // Wishbone decode: one access per ack, a held request is not re-acked
  // ---------------------------------------------------------------------------
  assign w_hit      = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign w_req      = w_hit & ~r_ack;
  assign w_wr       = w_req & wbs_we_i;
  assign w_sel_wr   = w_wr & (wbs_adr_i[7:2] == OFF_SEL);
  assign w_guard_wr = w_wr & (wbs_adr_i[7:2] == OFF_GUARD) & wbs_sel_i[0];

  assign w_unused = ^{wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:9]};

  // An index beyond the populated projects behaves as "all projects off".
  assign w_req_en_eff = r_req_en & (32'(r_req_idx) < 32'(NPROJ));
  assign w_same       = (r_req_idx == r_cur_idx) && (w_req_en_eff == r_cur_en);
  assign w_req_onehot = w_req_en_eff ? (NPROJ'(1) << r_req_idx) : '0;

  always_comb begin
    // NOTE: default every output of a combinational block first so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    w_rdata = '0;
    case (wbs_adr_i[7:2])
      OFF_SEL: begin
        w_rdata[4:0] = r_req_idx;
        w_rdata[8]   = r_req_en;
      end
      OFF_GUARD:  w_rdata[7:0] = r_guard;
      OFF_STATUS: w_rdata = {r_switch_cnt, 6'd0, r_busy, r_cur_en, 3'd0, r_cur_idx};
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack     <= 1'b0;
      r_dat     <= '0;
      r_req_idx <= '0;
      r_req_en  <= 1'b0;
      r_guard   <= GUARD_RST;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values; blocking here would create ordering races.
      r_ack <= w_req;
      r_dat <= (w_req && !wbs_we_i) ? w_rdata : '0;
      if (w_sel_wr) begin
        if (wbs_sel_i[0]) r_req_idx <= wbs_dat_i[4:0];
        if (wbs_sel_i[1]) r_req_en  <= wbs_dat_i[8];
      end
      if (w_guard_wr) r_guard <= wbs_dat_i[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Switch sequencer: IDLE -> DRAIN (GUARD+1 cycles) -> APPLY -> IDLE
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state      <= S_IDLE;
      r_gcnt       <= '0;
      r_pending    <= 1'b0;
      r_cur_idx    <= '0;
      r_cur_en     <= 1'b0;
      r_switch_cnt <= '0;
      r_active     <= '0;
      r_busy       <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_pending) begin
            if (w_same) begin
              r_pending <= 1'b0;
            end else begin
              r_state  <= S_DRAIN;
              r_gcnt   <= r_guard;
              r_active <= '0;
              r_busy   <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (r_gcnt == 8'd0) begin
            r_state <= S_APPLY;
            r_irq   <= 1'b1;
          end else begin
            r_gcnt <= r_gcnt - 8'd1;
          end
        end
        S_APPLY: begin
          r_cur_idx    <= r_req_idx;
          r_cur_en     <= w_req_en_eff;
          r_switch_cnt <= r_switch_cnt + 16'd1;
          r_active     <= w_req_onehot;
          r_busy       <= 1'b0;
          r_irq        <= 1'b0;
          r_pending    <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state  <= S_IDLE;
          r_active <= '0;
          r_busy   <= 1'b0;
          r_irq    <= 1'b0;
        end
      endcase
      // A SEL write on this edge always wins over any clear above, so a
      // request landing during APPLY triggers a follow-up switch.
      if (w_sel_wr) r_pending <= 1'b1;
    end
  end

  assign wbs_ack_o  = r_ack;
  assign wbs_dat_o  = r_dat;
  assign active     = r_active;
  assign busy       = r_busy;
  assign switch_irq = r_irq;

endmodule

// File: tb/tb_project_select_ctrl.sv
// Self-checking bench for project_select_ctrl: register table, directed switch sequences,
// and randomized switches checked against a transaction-level model of the selector.
`timescale 1ns/1ps

module tb_project_select_ctrl;

  localparam int          NPROJ = 16;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam logic [31:0] A_SEL = BASE + 32'h0;
  localparam logic [31:0] A_GRD = BASE + 32'h4;
  localparam logic [31:0] A_STS = BASE + 32'h8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]       sel = 4'h0;
  logic [31:0]      adr = '0, dat_i = '0;
  logic             ack;
  logic [31:0]      dat_o;
  logic [NPROJ-1:0] active;
  logic             busy, irq;

  int n_checks = 0;
  int n_fail   = 0;
  int irq_total = 0;
  logic [NPROJ-1:0] prev_active = '0;

  project_select_ctrl #(.NPROJ(NPROJ), .BASE_ADDR(BASE), .GUARD_RST(8'd16)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .active(active), .busy(busy), .switch_irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Continuous safety properties of the active vector, sampled mid-cycle.
  always @(negedge clk) begin
    if (irq) irq_total++;
    check("active_onehot0", 32'($countones(active) <= 1), 32'd1);
    check("no_direct_switch",
          32'((prev_active != '0) && (active != '0) && (active != prev_active)), 32'd0);
    prev_active = active;
  end

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic got_ack, output logic [31:0] rd);
    got_ack = 1'b0;
    rd = '0;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        got_ack = 1'b1;
        rd = dat_o;
        break;
      end
    end
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    logic k;
    logic [31:0] r;
    wb_xfer(1'b1, a, d, 4'hF, k, r);
    check("write_ack", 32'(k), 32'd1);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] rd);
    logic k;
    wb_xfer(1'b0, a, 32'd0, 4'hF, k, rd);
    check("read_ack", 32'(k), 32'd1);
  endtask

  // Follows one switch (if any) to completion: busy cycles seen, and whether
  // active stayed dark for all of them.
  task automatic wait_switch(output int bcyc, output logic dead_ok);
    bit seen = 1'b0;
    bcyc = 0;
    dead_ok = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (busy) begin
        seen = 1'b1;
        bcyc++;
        if (active != '0) dead_ok = 1'b0;
      end else if (seen || i >= 3) begin
        return;
      end
    end
    check("switch_timeout", 32'd1, 32'd0);
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        exp_ack;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  // Transaction-level model of the selected project.
  int   m_idx, m_cnt;
  logic m_en;

  initial begin
    logic [31:0] rd;
    logic        k;
    int          bc, irq0, g, idx;
    logic        dead, en, eff_en, same;

    tbl.push_back('{"rd_status_rst", 1'b0, A_STS, 32'h0,         4'hF, 1'b1, 32'h0});
    tbl.push_back('{"rd_guard_rst",  1'b0, A_GRD, 32'h0,         4'hF, 1'b1, 32'h10});
    tbl.push_back('{"rd_sel_rst",    1'b0, A_SEL, 32'h0,         4'hF, 1'b1, 32'h0});
    tbl.push_back('{"wr_guard",      1'b1, A_GRD, 32'h1234_5607, 4'hF, 1'b1, 32'h0});
    tbl.push_back('{"rd_guard",      1'b0, A_GRD, 32'h0,         4'hF, 1'b1, 32'h07});
    tbl.push_back('{"wr_guard_nob0", 1'b1, A_GRD, 32'h0000_00AB, 4'hE, 1'b1, 32'h0});
    tbl.push_back('{"rd_guard_kept", 1'b0, A_GRD, 32'h0,         4'hF, 1'b1, 32'h07});
    tbl.push_back('{"rd_unused_0c",  1'b0, BASE + 32'h0C, 32'h0, 4'hF, 1'b1, 32'h0});
    tbl.push_back('{"wr_unused_10",  1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0});
    tbl.push_back('{"rd_out_range",  1'b0, BASE + 32'h100, 32'h0, 4'hF, 1'b0, 32'h0});
    tbl.push_back('{"wr_out_range",  1'b1, 32'h3100_0004, 32'h55, 4'hF, 1'b0, 32'h0});
    tbl.push_back('{"rd_guard_same", 1'b0, A_GRD, 32'h0,         4'hF, 1'b1, 32'h07});
    tbl.push_back('{"wr_sel_same",   1'b1, A_SEL, 32'h0,         4'hF, 1'b1, 32'h0});
    tbl.push_back('{"rd_status_0",   1'b0, A_STS, 32'h0,         4'hF, 1'b1, 32'h0});
    tbl.push_back('{"wr_guard_16",   1'b1, A_GRD, 32'h10,        4'hF, 1'b1, 32'h0});
    tbl.push_back('{"rd_guard_16",   1'b0, A_GRD, 32'h0,         4'hF, 1'b1, 32'h10});

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_active", 32'(active), 32'h0);
    check("rst_busy",   32'(busy),   32'h0);
    check("rst_irq",    32'(irq),    32'h0);
    check("rst_ack",    32'(ack),    32'h0);
    check("rst_dat",    dat_o,       32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Register map table.
    for (int i = 0; i < tbl.size(); i++) begin
      wb_xfer(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, k, rd);
      check({tbl[i].name, "_ack"},  32'(k), 32'(tbl[i].exp_ack));
      check({tbl[i].name, "_data"}, rd,     tbl[i].exp_rd);
    end
    check("no_irq_after_table", 32'(irq_total), 32'd0);

    // A held request is acked once, not again on the following cycle.
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = A_GRD; sel = 4'hF;
    @(posedge clk); #1;
    check("held_first_ack", 32'(ack), 32'd1);
    @(posedge clk); #1;
    check("held_no_reack", 32'(ack), 32'd0);
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0;

    // Switch to project 9 with GUARD=16: 18 dark cycles, one irq.
    irq0 = irq_total;
    wb_write(A_SEL, 32'h109);
    wait_switch(bc, dead);
    check("sw9_busy_cycles", 32'(bc), 32'd18);
    check("sw9_dark", 32'(dead), 32'd1);
    check("sw9_irq", 32'(irq_total - irq0), 32'd1);
    check("sw9_active", 32'(active), 32'h200);
    wb_read(A_STS, rd);
    check("sw9_status", rd, 32'h0001_0109);

    // GUARD=0 still gives two dark cycles.
    wb_write(A_GRD, 32'h0);
    irq0 = irq_total;
    wb_write(A_SEL, 32'h10C);
    wait_switch(bc, dead);
    check("sw12_busy_cycles", 32'(bc), 32'd2);
    check("sw12_dark", 32'(dead), 32'd1);
    check("sw12_irq", 32'(irq_total - irq0), 32'd1);
    check("sw12_active", 32'(active), 32'h1000);
    wb_read(A_STS, rd);
    check("sw12_status", rd, 32'h0002_010C);

    // Same selection again: nothing happens.
    irq0 = irq_total;
    wb_write(A_SEL, 32'h10C);
    wait_switch(bc, dead);
    check("same_busy_cycles", 32'(bc), 32'd0);
    check("same_irq", 32'(irq_total - irq0), 32'd0);
    check("same_active", 32'(active), 32'h1000);
    wb_read(A_STS, rd);
    check("same_status", rd, 32'h0002_010C);

    // Request overwritten during DRAIN: one switch, ends on project 3.
    wb_write(A_GRD, 32'd10);
    irq0 = irq_total;
    wb_write(A_SEL, 32'h105);
    repeat (3) @(posedge clk);
    wb_write(A_SEL, 32'h103);
    wait_switch(bc, dead);
    check("drain_wr_dark", 32'(dead), 32'd1);
    check("drain_wr_irq", 32'(irq_total - irq0), 32'd1);
    check("drain_wr_active", 32'(active), 32'h8);
    wb_read(A_STS, rd);
    check("drain_wr_status", rd, 32'h0003_0103);

    // Request landing in the APPLY cycle: project 1 applied, then a second switch to 2.
    wb_write(A_GRD, 32'd0);
    irq0 = irq_total;
    wb_write(A_SEL, 32'h101);
    k = 1'b0;
    for (int i = 0; i < 20 && !k; i++) begin
      @(posedge clk); #1;
      k = irq;
    end
    check("apply_irq_seen", 32'(k), 32'd1);
    wb_write(A_SEL, 32'h102);
    wait_switch(bc, dead);
    check("apply_wr_irq", 32'(irq_total - irq0), 32'd2);
    check("apply_wr_active", 32'(active), 32'h4);
    wb_read(A_STS, rd);
    check("apply_wr_status", rd, 32'h0005_0102);

    // Randomized switches against the model.
    m_idx = 2; m_en = 1'b1; m_cnt = 5;
    for (int it = 0; it < 24; it++) begin
      g = $urandom_range(0, 6);
      idx = $urandom_range(0, 19);
      en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        idx = m_idx;
        en = m_en;
      end
      eff_en = en && (idx < NPROJ);
      same = (idx == m_idx) && (eff_en == m_en);
      wb_write(A_GRD, 32'(g));
      irq0 = irq_total;
      wb_write(A_SEL, (32'(en) << 8) | 32'(idx));
      wait_switch(bc, dead);
      if (!same) begin
        m_idx = idx;
        m_en = eff_en;
        m_cnt++;
      end
      check("rnd_busy_cycles", 32'(bc), same ? 32'd0 : 32'(g + 2));
      check("rnd_dark", 32'(dead), 32'd1);
      check("rnd_irq", 32'(irq_total - irq0), same ? 32'd0 : 32'd1);
      check("rnd_active", 32'(active), m_en ? (32'd1 << m_idx) : 32'd0);
      wb_read(A_STS, rd);
      check("rnd_status", rd, (32'(m_cnt) << 16) | (32'(m_en) << 8) | 32'(m_idx));
    end

    // Reset mid-DRAIN: outputs clear immediately, switch abandoned.
    wb_write(A_GRD, 32'd20);
    wb_write(A_SEL, 32'h100 | ((m_idx == 5) ? 32'd6 : 32'd5));
    repeat (4) @(posedge clk);
    #2;
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_active", 32'(active), 32'h0);
    check("arst_busy",   32'(busy),   32'h0);
    check("arst_irq",    32'(irq),    32'h0);
    check("arst_ack",    32'(ack),    32'h0);
    check("arst_dat",    dat_o,       32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (busy) bc++;
    end
    check("post_rst_no_switch", 32'(bc), 32'd0);
    check("post_rst_active", 32'(active), 32'h0);
    wb_read(A_STS, rd);
    check("post_rst_status", rd, 32'h0);
    wb_read(A_GRD, rd);
    check("post_rst_guard", rd, 32'h10);
    wb_read(A_SEL, rd);
    check("post_rst_sel", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
